// File: rtl/spi_gen_pkg.sv
// Shared state type and command encodings for the generic SPI slave front-end.
package spi_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    RD_WAIT,
    RD_SHIFT,
    HOLD
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_piso_tx.sv
// Load/shift-out register for SPI read data; owns the registered MISO output.
module spi_piso_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_en_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              miso_o,
  output logic              done_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              miso_q, miso_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    miso_d  = MISO_IDLE;
    if (load_i) begin
      shift_d = load_data_i;
      cnt_d   = CntW'(DATA_W);
    end else if (shift_en_i && (cnt_q != '0)) begin
      miso_d  = shift_q[DATA_W-1];
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      miso_q  <= MISO_IDLE;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
    end
  end

  assign miso_o = miso_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front-end for the RAM subsystem: {cmd, payload} frames in, read data out on MISO.
// Define SPI_BURST_EN to let a write-data frame continue as a stream of DATA_W-bit words.
module spi_slave_gen
  import spi_gen_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned RX_W = DATA_W + 2;
  localparam int unsigned CntW = $clog2(DATA_W + 2);
`ifdef SPI_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  spi_state_e      state_q, state_d;
  logic [RX_W-1:0] shift_q, shift_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RX_W-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rd_addr_done_q, rd_addr_done_d;
  logic            burst_q, burst_d;

  logic [RX_W-1:0] frame_word;
  logic            last_bit;
  logic            burst_start;
  logic            tx_load, tx_shift_en, tx_done;

  assign frame_word  = {shift_q[RX_W-2:0], MOSI};
  assign last_bit    = (cnt_q == CntW'(1));
  // Only the first completed write-data frame opens a burst; later words reuse burst_q.
  assign burst_start = BurstEn && !burst_q && (frame_word[RX_W-1:RX_W-2] == CMD_WR_DATA);
  assign tx_load     = (state_q == RD_WAIT) && !SS_n && tx_valid;
  assign tx_shift_en = (state_q == RD_SHIFT) && !SS_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = CHK_CMD;
        CHK_CMD:   state_d = !MOSI ? WRITE : (rd_addr_done_q ? READ_DATA : READ_ADD);
        WRITE:     if (last_bit && !burst_q && !burst_start) state_d = HOLD;
        READ_ADD:  if (last_bit) state_d = HOLD;
        READ_DATA: if (last_bit) state_d = RD_WAIT;
        RD_WAIT:   if (tx_valid) state_d = RD_SHIFT;
        RD_SHIFT:  if (tx_done) state_d = HOLD;
        HOLD:      state_d = HOLD;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    burst_d        = burst_q;
    if (SS_n) begin
      shift_d = '0;
      cnt_d   = '0;
      burst_d = 1'b0;
    end else begin
      unique case (state_q)
        CHK_CMD: begin
          shift_d = RX_W'(MOSI);
          cnt_d   = CntW'(DATA_W + 1);
        end
        WRITE, READ_ADD, READ_DATA: begin
          shift_d = frame_word;
          cnt_d   = cnt_q - CntW'(1);
          if (last_bit) begin
            rx_valid_d = 1'b1;
            rx_data_d  = burst_q ? {CMD_WR_DATA, frame_word[DATA_W-1:0]} : frame_word;
            if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
            if ((state_q == WRITE) && (burst_q || burst_start)) begin
              burst_d = 1'b1;
              cnt_d   = CntW'(DATA_W);
            end
          end
        end
        RD_SHIFT: if (tx_done) rd_addr_done_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q        <= '0;
      cnt_q          <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      burst_q        <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      burst_q        <= burst_d;
    end
  end

  spi_piso_tx #(
    .DATA_W   (DATA_W),
    .MISO_IDLE(MISO_IDLE)
  ) u_piso_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tx_load),
    .shift_en_i (tx_shift_en),
    .load_data_i(tx_data),
    .miso_o     (MISO),
    .done_o     (tx_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen: directed frames plus a random frame mix against a model.
module tb_spi_slave_gen;
  import spi_gen_pkg::*;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RX_W      = DATA_W + 2;
  localparam logic        MISO_IDLE = 1'b0;
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [RX_W-1:0]   rx_data;
  logic [DATA_W-1:0] tx_data;

  int checks = 0;
  int passes = 0;
  int strobes;

  // Reference model: last accepted frame and whether a read address is pending.
  logic [RX_W-1:0] m_rx_data;
  bit              m_rd_addr_done;

  always #5 clk = ~clk;

  spi_slave_gen #(
    .DATA_W   (DATA_W),
    .MISO_IDLE(MISO_IDLE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) strobes++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [1:0] cmd, input logic [DATA_W-1:0] pl, input int nbits,
                            output bit is_rd_data);
    logic [RX_W-1:0] f;
    f = {cmd, pl};
    is_rd_data = 1'b0;
    strobes = 0;
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[RX_W-1-i];
      tick();
    end
    if (nbits == RX_W) begin
      is_rd_data = cmd[1] && m_rd_addr_done;
      if (cmd[1] && !m_rd_addr_done) m_rd_addr_done = 1'b1;
      m_rx_data = f;
      check("frame_strobe_count", strobes, 1);
      check("frame_rx_valid", rx_valid, 1);
      check("frame_rx_data", rx_data, m_rx_data);
    end else begin
      SS_n = 1'b1;
      tick();
      tick();
      check("abort_strobes", strobes, 0);
      check("abort_rx_data", rx_data, m_rx_data);
      check("abort_miso", MISO, MISO_IDLE);
    end
  endtask

  // Stay selected with junk on MOSI and tx_valid; nothing must happen until deselect.
  task automatic hold(input int junk);
    strobes = 0;
    for (int i = 0; i < junk; i++) begin
      MOSI     = 1'($urandom);
      tx_valid = 1'($urandom);
      tx_data  = DATA_W'($urandom);
      tick();
      check("hold_miso", MISO, MISO_IDLE);
    end
    tx_valid = 1'b0;
    check("hold_strobes", strobes, 0);
    check("hold_rx_data", rx_data, m_rx_data);
    SS_n = 1'b1;
    tick();
  endtask

  task automatic read_phase(input int waits, input logic [DATA_W-1:0] data, input int cut,
                            input bit use_reset);
    tx_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      tx_data = DATA_W'($urandom);
      tick();
      check("rd_wait_miso", MISO, MISO_IDLE);
    end
    tx_data  = data;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = DATA_W'($urandom);
    for (int i = 0; i < cut; i++) begin
      tick();
      check("miso_bit", MISO, data[DATA_W-1-i]);
    end
    if (cut == DATA_W) begin
      tick();
      check("miso_after_read", MISO, MISO_IDLE);
      m_rd_addr_done = 1'b0;
      SS_n = 1'b1;
      tick();
    end else if (use_reset) begin
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_miso", MISO, MISO_IDLE);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      m_rx_data      = '0;
      m_rd_addr_done = 1'b0;
      SS_n = 1'b1;
      #3;
      rst_n = 1'b1;
      tick();
    end else begin
      SS_n = 1'b1;
      tick();
      check("rd_abort_miso", MISO, MISO_IDLE);
    end
  endtask

  initial begin
    bit                rd;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] pl;
    int                nbits;
    int                cut;

    rst_n = 1'b0;
    SS_n = 1'b1;
    MOSI = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    m_rx_data = '0;
    m_rd_addr_done = 1'b0;
    strobes = 0;
    #1;
    check("reset_miso", MISO, MISO_IDLE);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Write address, then write data followed by extra bits.
    send_frame(CMD_WR_ADDR, 8'hA5, RX_W, rd);
    check("wr_addr_word", rx_data, 10'h0A5);
    hold(3);
    send_frame(CMD_WR_DATA, 8'h3C, RX_W, rd);
    check("wr_data_word", rx_data, 10'h13C);
    hold(BURST ? 0 : 8);

    // Aborted write keeps the previous rx_data.
    send_frame(CMD_WR_DATA, 8'hFF, 5, rd);
    check("abort_keeps_13c", rx_data, 10'h13C);

    // Read address, read data with a delayed tx_valid, then a fresh read address.
    send_frame(CMD_RD_ADDR, 8'h55, RX_W, rd);
    check("rd_addr_word", rx_data, 10'h255);
    check("rd_addr_route", rd, 0);
    hold(4);
    send_frame(CMD_RD_DATA, 8'h00, RX_W, rd);
    check("rd_data_word", rx_data, 10'h300);
    check("rd_data_route", rd, 1);
    read_phase(3, 8'hC3, DATA_W, 1'b0);
    send_frame(CMD_RD_ADDR, 8'h12, RX_W, rd);
    hold(5);

    // Abort in RD_SHIFT, then a retried read-data frame is still accepted.
    send_frame(CMD_RD_DATA, 8'h9A, RX_W, rd);
    read_phase(2, 8'h6E, 4, 1'b0);
    send_frame(CMD_RD_DATA, 8'h9A, RX_W, rd);
    check("retry_route", rd, 1);
    read_phase(0, 8'hB1, DATA_W, 1'b0);

    // Reset in the middle of shifting read data.
    send_frame(CMD_RD_ADDR, 8'h0F, RX_W, rd);
    hold(0);
    send_frame(CMD_RD_DATA, 8'hF0, RX_W, rd);
    read_phase(1, 8'hA7, 3, 1'b1);
    send_frame(CMD_RD_DATA, 8'h44, RX_W, rd);
    check("post_reset_route", rd, 0);
    hold(5);

`ifdef SPI_BURST_EN
    send_frame(CMD_WR_DATA, 8'h11, RX_W, rd);
    pl = 8'h22;
    for (int k = 0; k < 2; k++) begin
      strobes = 0;
      for (int i = 0; i < DATA_W; i++) begin
        MOSI = pl[DATA_W-1-i];
        tick();
      end
      m_rx_data = {CMD_WR_DATA, pl};
      check("burst_strobes", strobes, 1);
      check("burst_rx_valid", rx_valid, 1);
      check("burst_rx_data", rx_data, m_rx_data);
      pl = 8'h33;
    end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'($urandom);
      tick();
    end
    SS_n = 1'b1;
    tick();
    check("burst_partial_strobes", strobes, 0);
    check("burst_partial_rx_data", rx_data, 10'h133);
`endif

    // Random frame mix against the model.
    for (int it = 0; it < 40; it++) begin
      cmd   = 2'($urandom);
      pl    = DATA_W'($urandom);
      nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, RX_W - 1)) : RX_W;
      send_frame(cmd, pl, nbits, rd);
      if (nbits == RX_W) begin
        if (rd) begin
          cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DATA_W - 1)) : DATA_W;
          read_phase(int'($urandom_range(0, 4)), DATA_W'($urandom), cut, 1'b0);
        end else begin
          hold((BURST && cmd == CMD_WR_DATA) ? 0 : int'($urandom_range(0, 6)));
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_gen.md
Name: spi_slave_gen

Overview:
- Parametrised SPI slave front-end for the single-port RAM subsystem.
- Deserialises MOSI frames of {2-bit command, DATA_W payload} into parallel words for the RAM, with a one-cycle rx_valid strobe.
- Serialises RAM read data back on MISO.
- Extends the first-generation slave with:
  - width parametrisation
  - a separate output register, so aborted frames never corrupt rx_data
  - tx_valid wait handling
  - MSB-first framing
  - optional burst writes
- SPI bit clock equals clk; MOSI and SS_n are sampled on posedge clk and are already synchronous.

Parameters:
- DATA_W, 8: payload width (address and data word); must be >= 2.
- MISO_IDLE, 1'b0: value driven on MISO whenever not shifting read data.

Ports:
- clk  in  1  system clock, also the SPI bit clock.
- rst_n  in  1  reset, asynchronous, active-low.
- SS_n  in  1  slave select, active-low; high aborts any frame.
- MOSI  in  1  serial data in, MSB-first.
- MISO  out  1  serial data out, MSB-first.
- rx_data  out  DATA_W+2  last completed frame {cmd[1:0], payload}.
- rx_valid  out  1  one-cycle strobe: rx_data newly updated.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid; sampled only in RD_WAIT.

Behaviour:
- Command encodings (cmd = first two frame bits):
  - 00 write address
  - 01 write data
  - 10 read address
  - 11 read data
- Reset (async) values:
  - MISO = MISO_IDLE, rx_valid = 0, rx_data = 0
  - state = IDLE, rd_addr_done = 0, shift/count registers = 0
- States and transitions:
  - IDLE: SS_n = 0 -> CHK_CMD.
  - CHK_CMD: samples MOSI as frame bit RX_W-1 (RX_W = DATA_W+2) into the shift register.
    - MOSI = 0 -> WRITE.
    - MOSI = 1 and rd_addr_done = 0 -> READ_ADD.
    - MOSI = 1 and rd_addr_done = 1 -> READ_DATA.
  - WRITE / READ_ADD / READ_DATA: shift DATA_W+1 further MOSI bits, MSB-first (shift left, MOSI into bit 0).
    - Counter loads DATA_W+1 in CHK_CMD and decrements per captured bit.
  - Frame completion:
    - On the edge capturing the last bit, rx_data <= full shift value.
    - rx_valid = 1 in the following cycle only.
    - Total latency: last bit edge + 1 cycle.
  - After completion:
    - WRITE -> HOLD.
    - READ_ADD -> HOLD; also sets rd_addr_done = 1.
    - READ_DATA -> RD_WAIT.
  - RD_WAIT: waits indefinitely for tx_valid = 1.
    - On tx_valid, latch tx_data into tx shift register, load counter DATA_W -> RD_SHIFT.
  - RD_SHIFT:
    - MISO = tx_shift[DATA_W-1] registered, one bit per cycle, MSB first.
    - After DATA_W bits: MISO = MISO_IDLE, rd_addr_done = 0 -> HOLD.
  - HOLD: MOSI ignored; SS_n = 1 -> IDLE.
- Command bit 2 is not policed: a frame entered via READ_ADD carries whatever cmd bits the master sent.
  - rx_data reports them verbatim; the RAM decodes.
- SS_n = 1 in any state except IDLE:
  - Next state IDLE; partial frame discarded.
  - No rx_valid; rx_data unchanged.
  - MISO = MISO_IDLE; rd_addr_done unchanged, except after RD_SHIFT completion.
  - Abort in RD_WAIT or RD_SHIFT leaves rd_addr_done = 1, so a retried read-data frame is accepted.
- tx_valid outside RD_WAIT is ignored.
- rx_valid is never asserted for two consecutive cycles in non-burst mode.
- Reset mid-operation returns all of the above to reset values at once; no partial strobe.

Optional Feature:
- SPI_BURST_EN defined: after a completed WRITE frame with cmd = 01 and SS_n still 0, no HOLD.
  - Each further DATA_W MOSI bits form a word.
  - rx_data = {2'b01, word}; rx_valid pulses 1 cycle after each word's last bit.
  - Repeats until SS_n = 1; a partial word is discarded.
  - Rate: one strobe per DATA_W cycles.
- SPI_BURST_EN undefined: extra bits after any frame are ignored in HOLD.

Decomposition:
- Package spi_gen_pkg:
  - state enum typedef: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT, HOLD
  - cmd localparams: CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA
- One sub-module, spi_piso_tx: parametrised DATA_W load/shift-out register with done flag; drives MISO.

Test Plan (DATA_W = 8):
- Write address: SS_n low, MOSI 0,0 then 0xA5 MSB-first -> single rx_valid pulse 1 cycle after last bit; rx_data = 10'h0A5.
- Write data: 0,1 + 0x3C -> rx_data = 10'h13C.
  - Extra 8 MOSI bits with macro off -> no further rx_valid.
- Read address then read data:
  - 1,0 + 0x55, SS_n high -> rx_data = 10'h255.
  - Next frame 1,1 + 0x00 -> rx_data = 10'h300.
  - tx_valid after 3 idle cycles with tx_data = 0xC3 -> MISO 1,1,0,0,0,0,1,1.
  - Subsequent read frame routes to READ_ADD.
- Abort: SS_n high after 5 bits of 0,1 + 0xFF -> no rx_valid; rx_data keeps prior 10'h13C; MISO = MISO_IDLE.
- Reset mid-RD_SHIFT (after 3 bits) -> MISO = MISO_IDLE, rx_valid = 0, rx_data = 0 immediately.
  - Next 1,x frame goes to READ_ADD.
- SPI_BURST_EN: 0,1 + 0x11 + 0x22 + 0x33 in one SS_n window -> three rx_valid pulses 8 cycles apart; rx_data 10'h111, 10'h122, 10'h133.
